// File: rtl/fifo_drain_ctrl.sv
// Read-side drain engine for the synchronous FIFO: issues reads, captures data into a 2-entry skid buffer and streams it downstream.
// Optional empty-FIFO timeout/abort is compiled in when FIFO_DRAIN_TIMEOUT_EN is defined.

module fifo_drain_ctrl #(
  parameter int FIFO_WIDTH     = 16,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_left,
  output logic                  abort
);

  // Downstream stream: a word moves when m_valid && m_ready on a rising edge;
  // m_valid never drops and m_data never changes while a word waits for m_ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [FIFO_WIDTH-1:0] skid_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  inflight;
  logic [1:0]            occupancy;
  logic [2:0]            credit;
  logic                  pop;
  logic                  issue;
  logic                  start_ok;
  logic                  timeout_hit;

  assign start_ok = (state == IDLE) && start;
  assign m_valid  = (occupancy != 2'd0);
  assign m_data   = skid_mem[rd_ptr];
  assign pop      = m_valid && m_ready;

  // Slots still committed after this cycle's pop; counting the pop keeps one read per clock at full rate.
  assign credit = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = !fifo_empty && (words_left != '0) && (credit < 3'd2) && !timeout_hit;
        if (timeout_hit || (issue && (words_left == LEN_WIDTH'(1)))) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (credit == 3'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_rd_en = issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      occupancy   <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      words_left  <= '0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
    end else begin
      inflight <= issue;
      if (start_ok && (burst_len != '0)) begin
        words_left <= burst_len;
      end else if (issue) begin
        words_left <= words_left - LEN_WIDTH'(1);
      end
      if (inflight) begin
        skid_mem[wr_ptr] <= fifo_data_out;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occupancy <= occupancy + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] empty_cnt;
  logic             abort_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive empty cycle spent in RUN.
  assign timeout_hit = (state == RUN) && fifo_empty &&
                       (empty_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign abort       = abort_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      empty_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      if ((state == RUN) && fifo_empty) begin
        empty_cnt <= empty_cnt + CNT_W'(1);
      end else begin
        empty_cnt <= '0;
      end
      if (timeout_hit) begin
        abort_q <= 1'b1;
      end else if (start_ok) begin
        abort_q <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign abort              = 1'b0;
`endif

endmodule
